forest_vote_sequencer: RTL and testbench
========================================

# forest_vote_sequencer

Sequences one feature vector at a time through an external bank of combinational decision-tree classifiers and takes a majority vote across trees. It registers the sample onto the shared feature bus and waits a fixed settle time. It then counts the tree votes one class per cycle and returns the winning class over a valid/ready handshake. It sits between the sample source and the downstream result consumer, alongside the generated classN_treeM instances.

## Interface
- N_FEAT, 51: feature vector width; matches the tree input bus.
- N_TREES, 5: trees per class; legal range 1..15.
- N_CLASSES, 3: number of classes; legal range 2..16.
- SETTLE, 2: wait cycles for the tree bank to settle after the feature bus updates; minimum 1.
- Derived: CW = clog2(N_CLASSES) and VW = clog2(N_TREES+1).

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: sample offered.
- in_ready, out, 1: block can accept a sample.
- in_feat, in, N_FEAT: sample features.
- feat_o, out, N_FEAT: registered feature bus driven to every tree instance.
- votes_i, in, N_CLASSES*N_TREES: tree outputs; bit c*N_TREES+t is tree t of class c.
- out_valid, out, 1: result available.
- out_ready, in, 1: consumer accepts the result.
- out_class, out, CW: winning class index.
- out_votes, out, VW: vote count of the winning class.
- busy, out, 1: high in any state except IDLE.

## Operation
- FSM has four states: IDLE, WAIT, COUNT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: feat_o<=in_feat, wait counter<=SETTLE-1, go to WAIT.
- WAIT:
  - votes_i is ignored.
  - Counter decrements each cycle. In the cycle the counter reads 0, go to COUNT with class pointer c=0, best_cnt=0, best_idx=0.
- COUNT, once per cycle:
  - Compute pop = popcount(votes_i[c*N_TREES +: N_TREES]).
  - If c==0 or pop > best_cnt: best_cnt<=pop and best_idx<=c. Comparison is strict greater-than, so ties resolve to the lowest class index.
  - If c==N_CLASSES-1, go to DONE; otherwise c<=c+1.
- DONE:
  - out_valid=1; out_class=best_idx; out_votes=best_cnt.
  - All outputs hold stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE. in_ready rises the following cycle; the handshake cycle itself does not accept a new sample.
- feat_o holds the last accepted sample until the next acceptance; it is not cleared on result handshake.
- The all-zero vote case is a valid result: out_class=0, out_votes=0.
- Arithmetic: popcount and best_cnt are VW bits wide and cannot overflow because N_TREES ≤ 2^VW − 1. c is a CW-bit counter with no wrap beyond N_CLASSES-1.
- Reset, asserted in any state including mid-WAIT or mid-COUNT:
  - State goes to IDLE.
  - feat_o, best_cnt, best_idx, c and the counter go to 0.
  - The in-flight sample is dropped with no partial result.
  - Reset wins over a simultaneous handshake.

## Timing
- Output values at and after reset: in_ready=1 (visible in the first cycle after rst deasserts), out_valid=0, out_class=0, out_votes=0, busy=0, feat_o=0.
- Latency: out_valid goes high exactly SETTLE+N_CLASSES cycles after the acceptance edge (5 with defaults).
- votes_i is sampled only during the N_CLASSES COUNT cycles, which start SETTLE cycles after feat_o updates.
- Throughput: one sample per SETTLE+N_CLASSES+2 cycles when out_ready is held at 1.
- in_ready is combinational from state only; it never depends on in_valid.

## Test plan
- Single classify:
  - Stimulus: defaults; in_feat=51'h1; votes_i class0=5'b00011, class1=5'b01111, class2=5'b00001.
  - Required: out_valid 5 cycles after accept; out_class=1, out_votes=4; feat_o=51'h1 from the cycle after accept.
- Tie-break:
  - Stimulus: class0=3 votes, class1=1 vote, class2=3 votes.
  - Required: out_class=0, out_votes=3. With all votes zero: out_class=0, out_votes=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 throughout.
  - Required: out_class, out_votes and out_valid stable; in_ready=0; no new sample taken; feat_o unchanged. Raise out_ready: handshake, then in_ready=1 next cycle.
- Settle masking:
  - Stimulus: toggle votes_i to all-ones during WAIT, then to class2-only (5'b11111) during COUNT.
  - Required: out_class=2, out_votes=5.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle in the second COUNT cycle.
  - Required: next cycle in IDLE with in_ready=1, out_valid=0, feat_o=0, busy=0; no result is ever emitted for the dropped sample.
- Back-to-back:
  - Stimulus: three samples with out_ready=1 throughout.
  - Required: three results in order, each spaced 7 cycles apart; each out_class matches the votes_i presented for its sample.

Source files
------------

// File: rtl/forest_vote_sequencer.sv
// forest_vote_sequencer: feeds one feature vector to a tree bank, waits to settle, majority-votes per class
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_feat     sample input handshake
//   feat_o                        registered feature bus to every tree instance
//   votes_i                       tree outputs, bit c*N_TREES+t = tree t of class c
//   out_valid/out_ready           result handshake
//   out_class/out_votes           winning class index and its vote count
//   busy                          high whenever not IDLE
module forest_vote_sequencer #(
    parameter int N_FEAT    = 51,
    parameter int N_TREES   = 5,
    parameter int N_CLASSES = 3,
    parameter int SETTLE    = 2,
    parameter int CW        = $clog2(N_CLASSES),
    parameter int VW        = $clog2(N_TREES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_FEAT-1:0]              in_feat,
    output logic [N_FEAT-1:0]              feat_o,
    input  logic [N_CLASSES*N_TREES-1:0]   votes_i,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CW-1:0]                  out_class,
    output logic [VW-1:0]                  out_votes,
    output logic                           busy
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, COUNT, DONE} state_t;
    state_t state, state_n;
    logic [SW-1:0] cnt;
    logic [CW-1:0] c, best_idx;
    logic [VW-1:0] best_cnt, pop;
    logic [N_TREES-1:0] slice;
    logic last;
    assign last = c == CW'(N_CLASSES - 1);
    assign slice = N_TREES'(votes_i >> (N_TREES * int'(c)));
    always_comb begin
        pop = '0;
        for (int t = 0; t < N_TREES; t++) pop = pop + VW'(slice[t]);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? WAIT : IDLE;
            WAIT:    state_n = cnt == '0 ? COUNT : WAIT;
            COUNT:   state_n = last ? DONE : COUNT;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_o   <= '0;
            cnt      <= '0;
            c        <= '0;
            best_cnt <= '0;
            best_idx <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    feat_o <= in_feat;
                    cnt    <= SW'(SETTLE - 1);
                end
                WAIT: if (cnt == '0) begin
                    c        <= '0;
                    best_cnt <= '0;
                    best_idx <= '0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                COUNT: begin
                    // strict compare keeps the lowest class index on ties
                    if (c == '0 || pop > best_cnt) begin
                        best_cnt <= pop;
                        best_idx <= c;
                    end
                    if (!last) c <= c + 1'b1;
                end
                default: ;
            endcase
        end
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_class = best_idx;
    assign out_votes = best_cnt;
endmodule

// File: tb/tb_forest_vote_sequencer.sv
// tb_forest_vote_sequencer: directed self-checking bench with an expected-result queue
module tb_forest_vote_sequencer;
    localparam int NT = 5;
    localparam int NC = 3;
    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0;
    logic in_ready;
    logic [50:0] in_feat = '0;
    logic [50:0] feat_o;
    logic [14:0] votes_i = '0;
    logic out_valid;
    logic out_ready = 0;
    logic [1:0] out_class;
    logic [2:0] out_votes;
    logic busy;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    typedef struct {int cls; int votes;} exp_t;
    exp_t sb[$];

    forest_vote_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_feat(in_feat), .feat_o(feat_o), .votes_i(votes_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_votes(out_votes), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [14:0] v);
        exp_t e;
        e.cls = 0;
        e.votes = 0;
        for (int k = 0; k < NC; k++) begin
            int n;
            n = $countones(v[k*NT +: NT]);
            if (k == 0 || n > e.votes) begin
                e.cls = k;
                e.votes = n;
            end
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [50:0] f, input logic [14:0] v);
        int n;
        n = 0;
        in_feat = f;
        votes_i = v;
        in_valid = 1;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        chk("accept_ready", in_ready, 1);
        tick;
        in_valid = 0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick;
            lat++;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_class"}, out_class, e.cls);
            chk({tag, "_votes"}, out_votes, e.votes);
        end
    endtask

    task automatic handshake;
        out_ready = 1;
        tick;
        out_ready = 0;
        chk("hs_valid_low", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
    endtask

    initial begin
        int lat;
        int last_cyc;
        logic [14:0] v;
        // reset values
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_votes", out_votes, 0);
        chk("rst_busy", busy, 0);
        chk("rst_feat", feat_o, 0);
        // single classify
        sb.push_back('{1, 4});
        send(51'h1, {5'b00001, 5'b01111, 5'b00011});
        chk("single_feat", feat_o, 51'h1);
        chk("single_busy", busy, 1);
        wait_valid(lat);
        chk("single_latency", lat, 5);
        check_result("single");
        handshake;
        // tie-break: class0 and class2 both have 3
        sb.push_back('{0, 3});
        send(51'h3, {5'b10101, 5'b00100, 5'b11100});
        wait_valid(lat);
        chk("tie_latency", lat, 5);
        check_result("tie");
        handshake;
        // all zero votes
        sb.push_back('{0, 0});
        send(51'h4, 15'h0);
        wait_valid(lat);
        check_result("zero");
        handshake;
        // backpressure with in_valid held high
        sb.push_back('{1, 5});
        send(51'h2A, {5'b00011, 5'b11111, 5'b00001});
        wait_valid(lat);
        chk("bp_latency", lat, 5);
        in_valid = 1;
        in_feat = 51'h7FF;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_class", out_class, 1);
            chk("bp_votes", out_votes, 5);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_feat", feat_o, 51'h2A);
            tick;
        end
        check_result("bp");
        out_ready = 1;
        tick;
        out_ready = 0;
        chk("bp_hs_in_ready", in_ready, 1);
        chk("bp_hs_feat", feat_o, 51'h2A);
        chk("bp_hs_valid", out_valid, 0);
        in_valid = 0;
        tick;
        chk("bp_no_accept", busy, 0);
        // settle masking: all-ones in WAIT must be ignored
        sb.push_back('{2, 5});
        send(51'h9, 15'h0);
        votes_i = '1;
        tick;
        tick;
        votes_i = {5'b11111, 10'b0};
        wait_valid(lat);
        chk("mask_latency", lat, 3);
        check_result("mask");
        handshake;
        // reset in second COUNT cycle drops the sample
        send(51'h5, {5'b00000, 5'b11111, 5'b00000});
        tick;
        tick;
        tick;
        chk("mid_busy", busy, 1);
        rst = 1;
        tick;
        rst = 0;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_feat", feat_o, 0);
        chk("mid_busy_low", busy, 0);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("mid_no_result", out_valid, 0);
        end
        // back-to-back with out_ready held
        out_ready = 1;
        last_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            v = 15'($urandom);
            sb.push_back(model(v));
            send(51'(i + 100), v);
            wait_valid(lat);
            chk("b2b_latency", lat, 5);
            if (i > 0) chk("b2b_spacing", cyc - last_cyc, 7);
            last_cyc = cyc;
            check_result("b2b");
            tick;
        end
        out_ready = 0;
        chk("b2b_idle", in_ready, 1);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
